mem_port_arbiter: RTL and testbench

- Shares the core's single-port synchronous RAM between two requesters: the instruction-fetch path and the load/store (LDR/STR) data path of the ARM32 processor.
- Issues at most one RAM access per cycle, applies data-priority arbitration with a fetch anti-starvation override, and routes read data back to whichever port issued the read.
- Sits between the processor's fetch/execute logic and the ram instance.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter_starve_cnt.sv | 29 ++
 rtl/mem_port_arbiter.sv | 91 +++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the ARM32 memory-port arbiter slice.
package arm_mem_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int BE_W       = 4;

  // Which requester, if any, owns the RAM read data returning this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } own_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and RAM port of the memory arbiter.
interface mem_port_arbiter_if
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              ram_en;
  logic [BE_W-1:0]   ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // The arbiter itself
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  // The processor side plus the RAM, as seen from outside the arbiter
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating counter of consecutive stalled fetch cycles.
module arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [3:0] MAX_C = 4'(MAX);

  logic [3:0] cnt;

  // Count stalled cycles, hold at MAX, clear whenever fetch is served or idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_max = (cnt == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store data.
// Data has priority; fetch overrides once it has stalled STARVE_MAX cycles.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus
);

  logic              fetch_win;
  logic              data_win;
  logic              sel_en;
  logic [BE_W-1:0]   sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              at_max;
  logic              stall_inc;
  logic              stall_clr;
  own_t              owner;
  own_t              owner_next;

  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall_inc),
    .clr     (stall_clr),
    .at_max  (at_max)
  );

  // Pick the winner and build the RAM command; everything idles in reset
  always_comb begin
    fetch_win  = 1'b0;
    data_win   = 1'b0;
    sel_en     = 1'b0;
    sel_we     = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    owner_next = OWN_NONE;
    if (reset_n) begin
      fetch_win = bus.if_req && (!bus.d_req || at_max);
      data_win  = bus.d_req && !fetch_win;
    end
    if (fetch_win) begin
      sel_en     = 1'b1;
      sel_addr   = bus.if_addr;
      owner_next = OWN_IF;
    end else if (data_win) begin
      sel_addr = bus.d_addr;
      if (bus.d_we) begin
        sel_en    = |bus.d_be;
        sel_we    = bus.d_be;
        sel_wdata = bus.d_wdata;
      end else begin
        sel_en     = 1'b1;
        owner_next = OWN_D;
      end
    end
  end

  assign stall_inc = bus.if_req && !fetch_win;
  assign stall_clr = !bus.if_req || fetch_win;

  // Remember who issued this cycle's read so next cycle's data goes to them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_next;
    end
  end

  assign bus.if_gnt    = fetch_win;
  assign bus.d_gnt     = data_win;
  assign bus.ram_en    = sel_en;
  assign bus.ram_we    = sel_we;
  assign bus.ram_addr  = sel_addr;
  assign bus.ram_wdata = sel_wdata;

  assign bus.if_rvalid = (owner == OWN_IF);
  assign bus.d_rvalid  = (owner == OWN_D);
  assign bus.if_rdata  = reset_n ? bus.ram_rdata : '0;
  assign bus.d_rdata   = reset_n ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first RAM model.
// RAM word i is preloaded with 32'hC0DE0000 | i.
module tb_mem_port_arbiter;

  logic clk;
  logic reset_n;
  int   compared;
  int   fails;

  logic [31:0] mem [0:4095];

  mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (12),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Preload the RAM image
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'hC0DE0000 | 32'(i);
    end
  end

  // Synchronous write-first single-port RAM
  always @(posedge clk) begin
    if (bus.ram_en) begin
      logic [31:0] word;
      word = mem[bus.ram_addr];
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_we[b]) word[b*8 +: 8] = bus.ram_wdata[b*8 +: 8];
      end
      mem[bus.ram_addr] <= word;
      bus.ram_rdata     <= word;
    end
  end

  // A pending fetch must not move its address before it is granted
  logic        prev_if_pend;
  logic [11:0] prev_if_addr;
  always @(posedge clk) begin
    if (prev_if_pend && bus.if_req) begin
      assert (bus.if_addr === prev_if_addr)
        else $error("[TB] FAIL if_addr_stable: observed %h expected %h", bus.if_addr, prev_if_addr);
    end
    prev_if_pend <= reset_n && bus.if_req && !bus.if_gnt;
    prev_if_addr <= bus.if_addr;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
      else begin
        fails++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] exp_dg;
  logic [9:0] exp_ifrv;
  logic [9:0] exp_drv;

  initial begin
    compared     = 0;
    fails        = 0;
    prev_if_pend = 1'b0;
    prev_if_addr = '0;
    bus.ram_rdata = '0;
    exp_dg   = 10'b0111101111;
    exp_ifrv = 10'b0000100000;
    exp_drv  = 10'b1111011110;

    // Reset held with a fetch already requesting
    reset_n     = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h010;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_be    = '0;
    repeat (2) @(negedge clk);
    check_output("rst_if_gnt",    32'(bus.if_gnt),    32'd0);
    check_output("rst_d_gnt",     32'(bus.d_gnt),     32'd0);
    check_output("rst_ram_en",    32'(bus.ram_en),    32'd0);
    check_output("rst_ram_we",    32'(bus.ram_we),    32'd0);
    check_output("rst_ram_addr",  32'(bus.ram_addr),  32'd0);
    check_output("rst_ram_wdata", bus.ram_wdata,      32'd0);
    check_output("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check_output("rst_d_rvalid",  32'(bus.d_rvalid),  32'd0);

    // Release: fetch granted in the same cycle
    reset_n = 1'b1;
    #1;
    check_output("t1_if_gnt",   32'(bus.if_gnt),   32'd1);
    check_output("t1_ram_en",   32'(bus.ram_en),   32'd1);
    check_output("t1_ram_addr", 32'(bus.ram_addr), 32'h010);
    check_output("t1_d_gnt",    32'(bus.d_gnt),    32'd0);
    next_cycle();
    bus.if_req = 1'b0;
    @(negedge clk);
    check_output("t1_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    check_output("t1_if_rdata",  bus.if_rdata,       32'hC0DE0010);
    check_output("t1_d_rvalid",  32'(bus.d_rvalid),  32'd0);

    // Back-to-back fetches 0,1,2
    next_cycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h000;
    @(negedge clk);
    check_output("t2_gnt0",    32'(bus.if_gnt),    32'd1);
    check_output("t2_rv_idle", 32'(bus.if_rvalid), 32'd0);
    next_cycle();
    bus.if_addr = 12'h001;
    @(negedge clk);
    check_output("t2_gnt1", 32'(bus.if_gnt),    32'd1);
    check_output("t2_rv0",  32'(bus.if_rvalid), 32'd1);
    check_output("t2_rd0",  bus.if_rdata,       32'hC0DE0000);
    next_cycle();
    bus.if_addr = 12'h002;
    @(negedge clk);
    check_output("t2_gnt2", 32'(bus.if_gnt),    32'd1);
    check_output("t2_rv1",  32'(bus.if_rvalid), 32'd1);
    check_output("t2_rd1",  bus.if_rdata,       32'hC0DE0001);
    next_cycle();
    bus.if_req = 1'b0;
    @(negedge clk);
    check_output("t2_gnt_off", 32'(bus.if_gnt),    32'd0);
    check_output("t2_rv2",     32'(bus.if_rvalid), 32'd1);
    check_output("t2_rd2",     bus.if_rdata,       32'hC0DE0002);

    // Partial write of the low half, then read it back
    next_cycle();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 12'h020;
    bus.d_wdata = 32'hDEADBEEF;
    bus.d_be    = 4'b0011;
    @(negedge clk);
    check_output("t3_wr_gnt",   32'(bus.d_gnt),     32'd1);
    check_output("t3_wr_en",    32'(bus.ram_en),    32'd1);
    check_output("t3_wr_we",    32'(bus.ram_we),    32'b0011);
    check_output("t3_wr_addr",  32'(bus.ram_addr),  32'h020);
    check_output("t3_wr_wdata", bus.ram_wdata,      32'hDEADBEEF);
    check_output("t3_if_rv",    32'(bus.if_rvalid), 32'd0);
    next_cycle();
    bus.d_we = 1'b0;
    bus.d_be = 4'b0000;
    @(negedge clk);
    check_output("t3_rd_gnt",   32'(bus.d_gnt),    32'd1);
    check_output("t3_rd_we",    32'(bus.ram_we),   32'd0);
    check_output("t3_wr_no_rv", 32'(bus.d_rvalid), 32'd0);
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge clk);
    check_output("t3_rd_rv",   32'(bus.d_rvalid),  32'd1);
    check_output("t3_rd_data", bus.d_rdata,        32'hC0DEBEEF);
    check_output("t3_if_rv2",  32'(bus.if_rvalid), 32'd0);

    // Both requesting continuously: fetch wins every fifth cycle
    next_cycle();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 12'h030;
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h040;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output($sformatf("t4_d_gnt_%0d", i),  32'(bus.d_gnt),     32'(exp_dg[i]));
      check_output($sformatf("t4_if_gnt_%0d", i), 32'(bus.if_gnt),    32'(!exp_dg[i]));
      check_output($sformatf("t4_if_rv_%0d", i),  32'(bus.if_rvalid), 32'(exp_ifrv[i]));
      check_output($sformatf("t4_d_rv_%0d", i),   32'(bus.d_rvalid),  32'(exp_drv[i]));
      if (exp_ifrv[i] || exp_drv[i]) begin
        check_output($sformatf("t4_rdata_%0d", i), bus.if_rdata,
                     exp_ifrv[i] ? 32'hC0DE0040 : 32'hC0DE0030);
      end
      next_cycle();
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    @(negedge clk);
    check_output("t4_tail_if_rv", 32'(bus.if_rvalid), 32'd1);
    check_output("t4_tail_d_rv",  32'(bus.d_rvalid),  32'd0);

    // Write with no byte enables: granted but no RAM access
    next_cycle();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_be    = 4'b0000;
    bus.d_addr  = 12'h050;
    bus.d_wdata = 32'h12345678;
    @(negedge clk);
    check_output("t5_gnt",    32'(bus.d_gnt),  32'd1);
    check_output("t5_ram_en", 32'(bus.ram_en), 32'd0);
    check_output("t5_ram_we", 32'(bus.ram_we), 32'd0);
    check_output("t5_if_gnt", 32'(bus.if_gnt), 32'd0);
    next_cycle();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clk);
    check_output("t5_no_rv", 32'(bus.d_rvalid), 32'd0);

    // Data read granted, then reset before the edge discards it
    next_cycle();
    bus.d_req  = 1'b1;
    bus.d_addr = 12'h060;
    @(negedge clk);
    check_output("t6_gnt",    32'(bus.d_gnt),  32'd1);
    check_output("t6_ram_en", 32'(bus.ram_en), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("t6_rst_d_gnt",  32'(bus.d_gnt),     32'd0);
    check_output("t6_rst_if_gnt", 32'(bus.if_gnt),    32'd0);
    check_output("t6_rst_en",     32'(bus.ram_en),    32'd0);
    check_output("t6_rst_addr",   32'(bus.ram_addr),  32'd0);
    check_output("t6_rst_d_rv",   32'(bus.d_rvalid),  32'd0);
    check_output("t6_rst_if_rv",  32'(bus.if_rvalid), 32'd0);
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_output("t6_rel_d_rv", 32'(bus.d_rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    check_output("t6_post_d_rv",  32'(bus.d_rvalid),  32'd0);
    check_output("t6_post_if_rv", 32'(bus.if_rvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end

endmodule
